// File: rtl/wb_pkg.sv
// Shared types for the register-file writeback arbiter: source encoding and default widths.
package wb_pkg;

  localparam int AW_DEF = 4;
  localparam int DW_DEF = 8;

  // Encoding doubles as the mux2CR value driven to the register file.
  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LD  = 1'b1
  } src_e;

  function automatic src_e other_src(input src_e s);
    return (s == SRC_ALU) ? SRC_LD : SRC_ALU;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small registered FIFO holding {addr, data} writeback entries for one source.
module wb_fifo #(
  parameter  int DEPTH = 2,
  parameter  int W     = 12,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  // A full FIFO refuses a push even when it is popped in the same cycle.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok)
      rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the ID register-file write port between the ALU and load
// writeback paths, each buffered by its own FIFO.
module regfile_wb_arbiter
  import wb_pkg::*;
#(
  parameter  int DEPTH = 2,
  parameter  int AW    = AW_DEF,
  parameter  int DW    = DW_DEF,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PNW   = $clog2(2 * DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           alu_vld,
  output logic           alu_rdy,
  input  logic [AW-1:0]  alu_addr,
  input  logic [DW-1:0]  alu_data,
  input  logic           ld_vld,
  output logic           ld_rdy,
  input  logic [AW-1:0]  ld_addr,
  input  logic [DW-1:0]  ld_data,
  output logic           RegCR,
  output logic [AW-1:0]  regaddrc,
  output logic           mux2CR,
  output logic [DW-1:0]  wb_in,
  output logic [DW-1:0]  wb_aord,
  output logic [PNW-1:0] pending
);

  localparam int W = AW + DW;

  logic [W-1:0]  alu_head, ld_head;
  logic          alu_full, alu_empty, ld_full, ld_empty;
  logic [CW-1:0] alu_cnt, ld_cnt;
  logic          alu_push, ld_push, alu_pop, ld_pop;

  logic          gnt_vld;
  src_e          gnt_src;

  src_e          last_q, last_d;
  logic          regcr_q, regcr_d;
  logic [AW-1:0] regaddrc_q, regaddrc_d;
  logic          mux2cr_q, mux2cr_d;
  logic [DW-1:0] wb_in_q, wb_in_d;
  logic [DW-1:0] wb_aord_q, wb_aord_d;

  assign alu_rdy  = !alu_full;
  assign ld_rdy   = !ld_full;
  assign alu_push = alu_vld && alu_rdy && !flush;
  assign ld_push  = ld_vld && ld_rdy && !flush;
  assign alu_pop  = gnt_vld && (gnt_src == SRC_ALU) && !flush;
  assign ld_pop   = gnt_vld && (gnt_src == SRC_LD) && !flush;

  wb_fifo #(.DEPTH(DEPTH), .W(W)) u_alu_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (alu_push),
    .din   ({alu_addr, alu_data}),
    .pop   (alu_pop),
    .dout  (alu_head),
    .full  (alu_full),
    .empty (alu_empty),
    .count (alu_cnt)
  );

  wb_fifo #(.DEPTH(DEPTH), .W(W)) u_ld_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (ld_push),
    .din   ({ld_addr, ld_data}),
    .pop   (ld_pop),
    .dout  (ld_head),
    .full  (ld_full),
    .empty (ld_empty),
    .count (ld_cnt)
  );

  always_comb begin
    gnt_vld = 1'b0;
    gnt_src = last_q;
    if (!alu_empty && !ld_empty) begin
      gnt_vld = 1'b1;
      gnt_src = other_src(last_q);
    end else if (!alu_empty) begin
      gnt_vld = 1'b1;
      gnt_src = SRC_ALU;
    end else if (!ld_empty) begin
      gnt_vld = 1'b1;
      gnt_src = SRC_LD;
    end
  end

  // Flush drops the write enable and pointer but leaves the data/address buses alone.
  always_comb begin
    last_d     = last_q;
    regcr_d    = 1'b0;
    regaddrc_d = regaddrc_q;
    mux2cr_d   = mux2cr_q;
    wb_in_d    = wb_in_q;
    wb_aord_d  = wb_aord_q;
    if (flush) begin
      last_d = SRC_LD;
    end else if (gnt_vld) begin
      last_d   = gnt_src;
      regcr_d  = 1'b1;
      mux2cr_d = logic'(gnt_src);
      if (gnt_src == SRC_ALU) begin
        regaddrc_d = alu_head[W-1:DW];
        wb_in_d    = alu_head[DW-1:0];
      end else begin
        regaddrc_d = ld_head[W-1:DW];
        wb_aord_d  = ld_head[DW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_q     <= SRC_LD;
      regcr_q    <= 1'b0;
      regaddrc_q <= '0;
      mux2cr_q   <= 1'b0;
      wb_in_q    <= '0;
      wb_aord_q  <= '0;
    end else begin
      last_q     <= last_d;
      regcr_q    <= regcr_d;
      regaddrc_q <= regaddrc_d;
      mux2cr_q   <= mux2cr_d;
      wb_in_q    <= wb_in_d;
      wb_aord_q  <= wb_aord_d;
    end
  end

  assign RegCR    = regcr_q;
  assign regaddrc = regaddrc_q;
  assign mux2CR   = mux2cr_q;
  assign wb_in    = wb_in_q;
  assign wb_aord  = wb_aord_q;
  assign pending  = PNW'(alu_cnt) + PNW'(ld_cnt);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: per-source scoreboards filled on accepted pushes and
// drained on each register-file write.
module tb_regfile_wb_arbiter;

  localparam int DEPTH = 2;
  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int PNW   = $clog2(2 * DEPTH + 1);

  typedef logic [AW+DW-1:0] ent_t;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           flush = 1'b0;
  logic           alu_vld = 1'b0, ld_vld = 1'b0;
  logic [AW-1:0]  alu_addr = '0, ld_addr = '0;
  logic [DW-1:0]  alu_data = '0, ld_data = '0;
  logic           alu_rdy, ld_rdy, RegCR, mux2CR;
  logic [AW-1:0]  regaddrc;
  logic [DW-1:0]  wb_in, wb_aord;
  logic [PNW-1:0] pending;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .alu_vld  (alu_vld),
    .alu_rdy  (alu_rdy),
    .alu_addr (alu_addr),
    .alu_data (alu_data),
    .ld_vld   (ld_vld),
    .ld_rdy   (ld_rdy),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .RegCR    (RegCR),
    .regaddrc (regaddrc),
    .mux2CR   (mux2CR),
    .wb_in    (wb_in),
    .wb_aord  (wb_aord),
    .pending  (pending)
  );

  always #5 clk = ~clk;

  ent_t          aq[$], lq[$];
  int            total = 0, passed = 0, cyc = 0;
  int            wr_cycles[$];
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_in = '0, exp_aord = '0;
  bit            a_acc, l_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Called with inputs settled after a falling edge; returns at the next falling edge.
  task automatic step();
    bit clr;
    clr   = !rst || flush;
    a_acc = alu_vld && alu_rdy && !clr;
    l_acc = ld_vld && ld_rdy && !clr;
    if (clr) begin
      aq.delete();
      lq.delete();
    end
    if (!rst) begin
      exp_addr = '0;
      exp_in   = '0;
      exp_aord = '0;
    end
    if (a_acc) aq.push_back({alu_addr, alu_data});
    if (l_acc) lq.push_back({ld_addr, ld_data});
    @(posedge clk);
    #1;
    cyc++;
    if (clr) chk("regcr_cleared", 32'(RegCR), 32'd0);
    if (RegCR === 1'b1) begin
      wr_cycles.push_back(cyc);
      if (mux2CR === 1'b0) begin
        chk("alu_write_expected", 32'(aq.size() != 0), 32'd1);
        if (aq.size() != 0) begin
          ent_t e;
          e = aq.pop_front();
          exp_addr = e[AW+DW-1:DW];
          exp_in   = e[DW-1:0];
        end
      end else begin
        chk("ld_write_expected", 32'(lq.size() != 0), 32'd1);
        if (lq.size() != 0) begin
          ent_t e;
          e = lq.pop_front();
          exp_addr = e[AW+DW-1:DW];
          exp_aord = e[DW-1:0];
        end
      end
    end
    chk("pending", 32'(pending), 32'(aq.size() + lq.size()));
    chk("regaddrc", 32'(regaddrc), 32'(exp_addr));
    chk("wb_in", 32'(wb_in), 32'(exp_in));
    chk("wb_aord", 32'(wb_aord), 32'(exp_aord));
    @(negedge clk);
  endtask

  task automatic load_three();
    alu_vld = 1'b1; alu_addr = 4'd12; alu_data = 8'h31;
    ld_vld  = 1'b1; ld_addr  = 4'd13; ld_data  = 8'h41;
    step();
    alu_addr = 4'd14; alu_data = 8'h32;
    ld_addr  = 4'd15; ld_data  = 8'h42;
    step();
    alu_vld = 1'b0;
    ld_vld  = 1'b0;
    chk("pre_clear_pending", 32'(pending), 32'd3);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ai, li;
    bit blocked;

    // Reset held for two cycles.
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    chk("rst_regcr", 32'(RegCR), 32'd0);
    chk("rst_mux2cr", 32'(mux2CR), 32'd0);
    chk("rst_alu_rdy", 32'(alu_rdy), 32'd1);
    chk("rst_ld_rdy", 32'(ld_rdy), 32'd1);

    // Single ALU write: registered, one cycle of latency after the push edge.
    alu_vld = 1'b1; alu_addr = 4'd11; alu_data = 8'd80;
    step();
    alu_vld = 1'b0;
    chk("single_no_bypass", 32'(RegCR), 32'd0);
    step();
    chk("single_wr", 32'(RegCR), 32'd1);
    chk("single_src", 32'(mux2CR), 32'd0);
    chk("single_data", 32'(wb_in), 32'd80);
    step();
    chk("single_idle", 32'(RegCR), 32'd0);

    // Flush returns the pointer to LOAD so the ALU wins the next tie.
    flush = 1'b1;
    step();
    flush = 1'b0;

    // Contention.
    alu_vld = 1'b1; alu_addr = 4'd3; alu_data = 8'h10;
    ld_vld  = 1'b1; ld_addr  = 4'd5; ld_data  = 8'h5A;
    step();
    alu_vld = 1'b0;
    ld_vld  = 1'b0;
    step();
    chk("cont_first_wr", 32'(RegCR), 32'd1);
    chk("cont_first_src", 32'(mux2CR), 32'd0);
    step();
    chk("cont_second_wr", 32'(RegCR), 32'd1);
    chk("cont_second_src", 32'(mux2CR), 32'd1);
    chk("cont_second_addr", 32'(regaddrc), 32'd5);
    chk("cont_second_aord", 32'(wb_aord), 32'h5A);
    chk("cont_in_held", 32'(wb_in), 32'h10);
    step();
    chk("cont_idle", 32'(RegCR), 32'd0);

    // Backpressure: one lone ALU write leaves the pointer at ALU, then both sources stream.
    alu_vld = 1'b1; alu_addr = 4'd7; alu_data = 8'h70;
    step();
    ai = 0;
    li = 0;
    blocked = 1'b0;
    for (int c = 0; c < 40 && (ai < 3 || li < 4); c++) begin
      alu_vld  = (ai < 3);
      alu_addr = AW'(8 + ai);
      alu_data = DW'(8'h81 + ai);
      ld_vld   = (li < 4);
      ld_addr  = AW'(1 + li);
      ld_data  = DW'(8'hA1 + li);
      if (alu_vld && !alu_rdy) blocked = 1'b1;
      step();
      if (a_acc) ai++;
      if (l_acc) li++;
    end
    alu_vld = 1'b0;
    ld_vld  = 1'b0;
    chk("bp_alu_blocked", 32'(blocked), 32'd1);
    chk("bp_alu_accepted", 32'(ai), 32'd3);
    chk("bp_ld_accepted", 32'(li), 32'd4);
    for (int c = 0; c < 20 && (aq.size() + lq.size()) != 0; c++) step();
    chk("bp_drained", 32'(aq.size() + lq.size()), 32'd0);
    step();

    // Flush with three entries queued: nothing queued may ever be written.
    load_three();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_pending", 32'(pending), 32'd0);
    chk("flush_regcr", 32'(RegCR), 32'd0);
    wr_cycles.delete();
    repeat (4) step();
    chk("flush_no_writes", 32'(wr_cycles.size()), 32'd0);

    // Same with reset, which also clears the buses.
    load_three();
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("rstq_pending", 32'(pending), 32'd0);
    chk("rstq_regcr", 32'(RegCR), 32'd0);
    chk("rstq_addr", 32'(regaddrc), 32'd0);
    chk("rstq_mux2cr", 32'(mux2CR), 32'd0);
    chk("rstq_in", 32'(wb_in), 32'd0);
    chk("rstq_aord", 32'(wb_aord), 32'd0);
    wr_cycles.delete();
    repeat (4) step();
    chk("rstq_no_writes", 32'(wr_cycles.size()), 32'd0);

    // Wrap-around: ten back-to-back ALU writes, one per cycle.
    wr_cycles.delete();
    ai = 0;
    for (int i = 0; i < 10; i++) begin
      alu_vld  = 1'b1;
      alu_addr = AW'(i);
      alu_data = DW'(16 + i);
      step();
      if (a_acc) ai++;
    end
    alu_vld = 1'b0;
    for (int c = 0; c < 6 && aq.size() != 0; c++) step();
    chk("wrap_accepted", 32'(ai), 32'd10);
    chk("wrap_writes", 32'(wr_cycles.size()), 32'd10);
    if (wr_cycles.size() == 10)
      chk("wrap_consecutive", 32'(wr_cycles[9] - wr_cycles[0]), 32'd9);
    chk("wrap_drained", 32'(aq.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the single write port of the ID-stage register file between two writeback sources: the ALU result path and the memory-load path. Each source has a small FIFO. A round-robin arbiter drains the FIFOs and drives the write-port controls: write enable RegCR, write address regaddrc, and source select mux2CR. The ALU value goes on the "in" data input and the load value on the AorD data input. The block sits between EX/MEM and ID.

Parameters:
DEPTH, 2, entries per source FIFO (power of 2, minimum 2)
AW, 4, register address width
DW, 8, data width

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset; synchronous, active-low; sampled on rising clk edge
flush  in  1  synchronous clear of both FIFOs and the arbiter state
alu_vld  in  1  ALU writeback request
alu_rdy  out  1  ALU FIFO can accept (not full)
alu_addr  in  AW  ALU destination register
alu_data  in  DW  ALU result
ld_vld  in  1  load writeback request
ld_rdy  out  1  load FIFO can accept (not full)
ld_addr  in  AW  load destination register
ld_data  in  DW  load data
RegCR  out  1  register-file write enable
regaddrc  out  AW  register-file write address
mux2CR  out  1  0 = write from "in" (ALU), 1 = write from AorD (load)
wb_in  out  DW  drives ID "in"
wb_aord  out  DW  drives ID AorD
pending  out  3  total entries held across both FIFOs

Behaviour:
- Reset (rst=0 at an edge): FIFOs empty; RegCR=0, regaddrc=0, mux2CR=0, wb_in=0, wb_aord=0, pending=0; alu_rdy=ld_rdy=1 from the next cycle; last-grant pointer = LOAD, so the ALU wins the first tie.
- Reset mid-operation discards all queued writes. No partial write is issued.
- flush=1 behaves like reset for the FIFOs, the pointer and RegCR. The data/address outputs hold their values. flush has priority over a simultaneous push.
- Handshake: a push happens on an edge where vld && rdy. rdy = !full only. A full FIFO refuses a push even if it is popped in the same cycle. vld is ignored while rdy=0, and the source must hold it.
- Arbitration happens each cycle on the FIFO heads:
  - Neither FIFO non-empty: no grant.
  - One non-empty: grant it.
  - Both non-empty: grant the source not granted last, then update the pointer.
  - The pointer updates only on a grant.
- A granted head is popped at that edge. Output registers load at the same edge:
  - RegCR=1, regaddrc=head addr, mux2CR=source.
  - The granted source's data bus = head data. The other data bus holds its previous value.
- With no grant, RegCR=0 at the next edge.
- Latency: a push into an empty FIFO at edge N, with no contention, gives RegCR=1 from edge N+1 to N+2. Sustained throughput is 1 write/cycle total.
- Push into an empty FIFO never bypasses combinationally; the FIFO must be registered first.
- Ordering: each source is FIFO-ordered. Between sources, order follows grant order. Same-address WAW across sources resolves by grant order; upstream owns hazard avoidance.
- Simultaneous push and pop on the same FIFO: count unchanged, pointers both advance, wrap at DEPTH.
- pending = alu_count + ld_count, registered, maximum 2*DEPTH.

Decomposition:
- Package wb_pkg: SRC_ALU=1'b0, SRC_LD=1'b1 (match mux2CR encoding), default AW/DW.
- Sub-module wb_fifo (parameters DEPTH, AW+DW): push/pop/full/empty/count, synchronous active-low rst, flush. Instantiated twice.
- Arbiter and output registers live in the top module.

Test Plan:
- Reset check: rst=0 for 2 cycles, with rst released -> all outputs 0, alu_rdy=ld_rdy=1, pending=0.
- Single ALU write: alu_vld=1, addr=11, data=80, one cycle -> next cycle RegCR=1, regaddrc=11, mux2CR=0, wb_in=80; following cycle RegCR=0.
- Contention: push ALU (addr=3, data=0x10) and load (addr=5, data=0x5A) in the same cycle -> grants are ALU first, then load. Load grant shows mux2CR=1, wb_aord=0x5A, regaddrc=5.
- Full/backpressure, DEPTH=2: hold arbitration busy by pushing the load FIFO continuously, then push 3 ALU requests back to back -> after 2 accepted, alu_rdy=0. The third request stays held and is accepted once an ALU pop frees space. pending peaks at 4.
- Flush/reset mid-queue: with 3 entries pending, assert flush -> next cycle pending=0, RegCR=0, and no queued write ever appears. Repeat with rst=0: same result plus all outputs 0.
- Wrap-around: stream 10 ALU writes (addr i, data 16+i) with no load traffic -> 10 consecutive RegCR pulses with data in order, pointer wraps without loss.
